// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm feeder path: controller state encoding,
// default geometry and packed-bus width helper.
package mvm_pkg;

   localparam int DEF_MATRIX_ROWS = 3;
   localparam int DEF_SHARED_DIM  = 3;
   localparam int DEF_WIDTH       = 8;

   typedef enum logic [2:0] {
      LOAD_M = 3'd0,
      LOAD_V = 3'd1,
      CLR    = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      DRAIN  = 3'd5
   } mvm_state_e;

   function automatic int bus_width(input int n_elems, input int width);
      return n_elems * width;
   endfunction

endpackage

// File: rtl/mvm_result_serializer.sv
// Parallel-load shift register that drains its contents MSB element first,
// one element per valid/ready handshake.
module mvm_result_serializer #(
   parameter int N_ELEMS = 3,
   parameter int WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       load_i,
   input  logic [N_ELEMS*WIDTH-1:0]   par_i,
   output logic [WIDTH-1:0]           out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       last_o
);

   localparam int CW = $clog2(N_ELEMS + 1);

   logic [N_ELEMS*WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     valid_q, valid_d;
   logic                     fire;

   assign fire = valid_q & out_ready_i;

   always_comb begin
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (load_i) begin
         sh_d    = par_i;
         cnt_d   = CW'(N_ELEMS);
         valid_d = 1'b1;
      end else if (fire) begin
         sh_d    = sh_q << WIDTH;
         cnt_d   = cnt_q - CW'(1);
         valid_d = (cnt_q != CW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign out_data_o  = sh_q[N_ELEMS*WIDTH-1 -: WIDTH];
   assign out_valid_o = valid_q;
   assign last_o      = fire && (cnt_q == CW'(1));

endmodule

// File: rtl/mvm_feeder.sv
// Streams operands into an mvm instance, sequences its reset/start/done
// protocol and streams the result back out. Watchdog: MVM_FEEDER_TIMEOUT_EN.
//
// state  | meaning
// LOAD_M | accepting matrix elements, row-major, MSB slot first
// LOAD_V | accepting vector elements
// CLR    | one-cycle mvm_reset
// START  | one-cycle mvm_start
// WAIT   | waiting for mvm_done (optionally bounded by the watchdog)
// DRAIN  | streaming result elements out
module mvm_feeder
   import mvm_pkg::*;
#(
   parameter int MATRIX_ROWS    = DEF_MATRIX_ROWS,
   parameter int SHARED_DIM     = DEF_SHARED_DIM,
   parameter int WIDTH          = DEF_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                                clk,
   input  logic                                                reset_n,
   input  logic [WIDTH-1:0]                                    in_data,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   output logic [WIDTH-1:0]                                    out_data,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic                                                mvm_reset,
   output logic                                                mvm_start,
   output logic [bus_width(MATRIX_ROWS*SHARED_DIM, WIDTH)-1:0] mvm_matrix,
   output logic [bus_width(SHARED_DIM, WIDTH)-1:0]             mvm_vector,
   input  logic [bus_width(MATRIX_ROWS, WIDTH)-1:0]            mvm_result,
   input  logic                                                mvm_done,
   output logic                                                busy,
   output logic                                                err_timeout
);

   localparam int N_M   = MATRIX_ROWS * SHARED_DIM;
   localparam int MW    = bus_width(N_M, WIDTH);
   localparam int VW    = bus_width(SHARED_DIM, WIDTH);
   localparam int CNT_W = $clog2(N_M + 1);
   localparam logic [CNT_W-1:0] LAST_M = CNT_W'(N_M - 1);
   localparam logic [CNT_W-1:0] LAST_V = CNT_W'(SHARED_DIM - 1);

   mvm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MW-1:0]    mat_q, mat_d;
   logic [VW-1:0]    vec_q, vec_d;
   logic             in_fire;
   logic             ser_load;
   logic             ser_last;
   logic             tmo;

   assign in_fire = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= LOAD_M;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD_M:  if (in_fire && cnt_q == LAST_M) state_d = LOAD_V;
         LOAD_V:  if (in_fire && cnt_q == LAST_V) state_d = CLR;
         CLR:     state_d = START;
         START:   state_d = WAIT;
         WAIT: begin
            if (mvm_done) state_d = DRAIN;
            else if (tmo) state_d = LOAD_M;
         end
         DRAIN:   if (ser_last) state_d = LOAD_M;
         default: state_d = LOAD_M;
      endcase
   end

   // reset_n gates the handshake and mvm controls so they show reset values while held
   always_comb begin
      in_ready  = reset_n && (state_q == LOAD_M || state_q == LOAD_V);
      mvm_reset = !reset_n || (state_q == CLR);
      mvm_start = reset_n && (state_q == START);
      busy      = reset_n && !(state_q == LOAD_M && cnt_q == '0);
      ser_load  = (state_q == WAIT) && mvm_done;
   end

   always_comb begin
      cnt_d = cnt_q;
      mat_d = mat_q;
      vec_d = vec_q;
      if (in_fire) begin
         if (state_q == LOAD_M) begin
            for (int k = 0; k < N_M; k++)
               if (cnt_q == CNT_W'(k)) mat_d[(N_M-1-k)*WIDTH +: WIDTH] = in_data;
            cnt_d = (cnt_q == LAST_M) ? '0 : cnt_q + CNT_W'(1);
         end else begin
            for (int k = 0; k < SHARED_DIM; k++)
               if (cnt_q == CNT_W'(k)) vec_d[(SHARED_DIM-1-k)*WIDTH +: WIDTH] = in_data;
            cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         mat_q <= '0;
         vec_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         mat_q <= mat_d;
         vec_q <= vec_d;
      end
   end

   assign mvm_matrix = mat_q;
   assign mvm_vector = vec_q;

`ifdef MVM_FEEDER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             err_q, err_d;

   assign tmo = (state_q == WAIT) && !mvm_done && (tmr_q == '0);

   always_comb begin
      tmr_d = tmr_q;
      err_d = err_q | tmo;
      if (state_q == START)                    tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
      else if (state_q == WAIT && tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmr_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         err_q <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign tmo         = 1'b0;
   // constant 0; the comparison only keeps the watchdog parameter referenced
   assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

   mvm_result_serializer #(
      .N_ELEMS (MATRIX_ROWS),
      .WIDTH   (WIDTH)
   ) u_ser (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (ser_load),
      .par_i       (mvm_result),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .last_o      (ser_last)
   );

endmodule

// File: tb/tb_mvm_feeder.sv
// Scoreboard bench for mvm_feeder: a 3x3 and a 2x4 instance, each attached
// to a behavioural mvm with a few cycles of compute latency.
module tb_mvm_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- 3x3 instance ----------------
   logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_in_data, a_out_data;
   logic        a_mvm_reset, a_mvm_start, a_mvm_done, a_busy, a_err_timeout;
   logic [71:0] a_mvm_matrix;
   logic [23:0] a_mvm_vector;
   logic [23:0] a_mvm_result = '0;
   logic        a_done_en;
   int          a_lat = 0;
   logic [7:0]  a_exp[$];

   mvm_feeder #(.MATRIX_ROWS(3), .SHARED_DIM(3), .WIDTH(8), .TIMEOUT_CYCLES(16)) u_a (
      .clk(clk), .reset_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .mvm_reset(a_mvm_reset), .mvm_start(a_mvm_start),
      .mvm_matrix(a_mvm_matrix), .mvm_vector(a_mvm_vector), .mvm_result(a_mvm_result),
      .mvm_done(a_mvm_done), .busy(a_busy), .err_timeout(a_err_timeout));

   // ---------------- 2x4 instance ----------------
   logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_out_data;
   logic        b_mvm_reset, b_mvm_start, b_mvm_done, b_busy, b_err_timeout;
   logic [63:0] b_mvm_matrix;
   logic [31:0] b_mvm_vector;
   logic [15:0] b_mvm_result = '0;
   int          b_lat = 0;
   logic [7:0]  b_exp[$];

   mvm_feeder #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(8)) u_b (
      .clk(clk), .reset_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .mvm_reset(b_mvm_reset), .mvm_start(b_mvm_start),
      .mvm_matrix(b_mvm_matrix), .mvm_vector(b_mvm_vector), .mvm_result(b_mvm_result),
      .mvm_done(b_mvm_done), .busy(b_busy), .err_timeout(b_err_timeout));

   // ---------------- behavioural mvm cores ----------------
   function automatic logic [23:0] mvm33(input logic [71:0] m, input logic [23:0] v);
      logic [23:0] r = '0;
      for (int i = 0; i < 3; i++) begin
         logic [7:0] acc = '0;
         for (int j = 0; j < 3; j++)
            acc += m[(8-(i*3+j))*8 +: 8] * v[(2-j)*8 +: 8];
         r[(2-i)*8 +: 8] = acc;
      end
      return r;
   endfunction

   function automatic logic [15:0] mvm24(input logic [63:0] m, input logic [31:0] v);
      logic [15:0] r = '0;
      for (int i = 0; i < 2; i++) begin
         logic [7:0] acc = '0;
         for (int j = 0; j < 4; j++)
            acc += m[(7-(i*4+j))*8 +: 8] * v[(3-j)*8 +: 8];
         r[(1-i)*8 +: 8] = acc;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (a_mvm_reset) begin
         a_mvm_done <= 1'b0;
         a_lat      <= 0;
      end else if (a_mvm_start) begin
         a_mvm_result <= mvm33(a_mvm_matrix, a_mvm_vector);
         a_lat        <= 3;
      end else if (a_lat != 0) begin
         a_lat <= a_lat - 1;
         if (a_lat == 1 && a_done_en) a_mvm_done <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (b_mvm_reset) begin
         b_mvm_done <= 1'b0;
         b_lat      <= 0;
      end else if (b_mvm_start) begin
         b_mvm_result <= mvm24(b_mvm_matrix, b_mvm_vector);
         b_lat        <= 2;
      end else if (b_lat != 0) begin
         b_lat <= b_lat - 1;
         if (b_lat == 1) b_mvm_done <= 1'b1;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired, required event did not occur", nm);
   endtask

   // ---------------- monitors (sample 1 time unit after the falling edge) ----------------
   logic       a_pv = 1'b0, a_pr = 1'b0;
   logic [7:0] a_pd = '0;
   always @(negedge clk) begin
      #1;
      if (a_rst_n) begin
         if (a_pv && !a_pr) check("a_stall_hold", {a_out_valid, a_out_data}, {1'b1, a_pd});
         if (a_out_valid && a_out_ready) begin
            if (a_exp.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL a_unexpected_out: got %0h, required no output", a_out_data);
            end else check("a_out", a_out_data, a_exp.pop_front());
         end
      end
      a_pv = a_rst_n && a_out_valid;
      a_pr = a_out_ready;
      a_pd = a_out_data;
   end

   logic       b_pv = 1'b0, b_pr = 1'b0;
   logic [7:0] b_pd = '0;
   always @(negedge clk) begin
      #1;
      if (b_rst_n) begin
         if (b_pv && !b_pr) check("b_stall_hold", {b_out_valid, b_out_data}, {1'b1, b_pd});
         if (b_out_valid && b_out_ready) begin
            if (b_exp.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL b_unexpected_out: got %0h, required no output", b_out_data);
            end else check("b_out", b_out_data, b_exp.pop_front());
         end
      end
      b_pv = b_rst_n && b_out_valid;
      b_pr = b_out_ready;
      b_pd = b_out_data;
   end

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic a_send(input logic [7:0] d, input bit keep);
      int n = 0;
      a_in_data  = d;
      a_in_valid = 1'b1;
      while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail_now("a_send_wait");
      @(negedge clk);
      if (!keep) a_in_valid = 1'b0;
   endtask

   task automatic b_send(input logic [7:0] d);
      int n = 0;
      b_in_data  = d;
      b_in_valid = 1'b1;
      while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail_now("b_send_wait");
      @(negedge clk);
      b_in_valid = 1'b0;
   endtask

   task automatic a_wait_idle(input string nm);
      int n = 0;
      while (a_busy && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) fail_now(nm);
   endtask

   task automatic a_op(input logic [7:0] ops[12], input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] r2, input bit gaps, input bit hold,
                       input logic [71:0] em, input logic [23:0] ev);
      a_exp.push_back(r0);
      a_exp.push_back(r1);
      a_exp.push_back(r2);
      for (int i = 0; i < 12; i++) begin
         a_send(ops[i], hold && i == 11);
         if (gaps && i < 11) begin
            a_in_data = 8'hAA;
            @(negedge clk);
         end
      end
      if (hold) a_in_data = 8'hFF;
      check("a_clr_mvm_reset", a_mvm_reset, 1'b1);
      check("a_clr_in_ready", a_in_ready, 1'b0);
      check("a_clr_busy", a_busy, 1'b1);
      @(negedge clk);
      check("a_start_mvm_reset", a_mvm_reset, 1'b0);
      check("a_start_mvm_start", a_mvm_start, 1'b1);
      check("a_start_in_ready", a_in_ready, 1'b0);
      @(negedge clk);
      check("a_wait_mvm_start", a_mvm_start, 1'b0);
      check("a_wait_in_ready", a_in_ready, 1'b0);
      check("a_matrix", a_mvm_matrix, em);
      check("a_vector", a_mvm_vector, ev);
      if (hold) begin
         @(negedge clk);
         check("a_hold_in_ready", a_in_ready, 1'b0);
         check("a_hold_matrix", a_mvm_matrix, em);
         a_in_valid = 1'b0;
      end
      a_wait_idle("a_op_idle");
      check("a_drained", a_exp.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   logic [7:0] ops1[12], ops2[12], ops3[12];

   initial begin
      ops1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h01, 8'h02, 8'h03};
      ops2 = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h07, 8'h08, 8'h09};
      ops3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
      a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_done_en = 1'b1;
      b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_in_ready", a_in_ready, 1'b0);
      check("rst_mvm_reset", a_mvm_reset, 1'b1);
      check("rst_mvm_start", a_mvm_start, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_err", a_err_timeout, 1'b0);
      check("rst_matrix", a_mvm_matrix, 72'h0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", a_in_ready, 1'b1);
      check("idle_mvm_reset", a_mvm_reset, 1'b0);
      check("idle_busy", a_busy, 1'b0);

      // basic 3x3
      a_op(ops1, 8'h0E, 8'h20, 8'h32, 1'b0, 1'b0, 72'h010203040506070809, 24'h010203);
      // products and sums wrap mod 256
      a_op(ops2, 8'hE2, 8'h2A, 8'h72, 1'b0, 1'b0, 72'h131415161718191A1B, 24'h070809);
      // input gaps, then in_valid held through CLR/START/WAIT
      a_op(ops1, 8'h0E, 8'h20, 8'h32, 1'b1, 1'b1, 72'h010203040506070809, 24'h010203);

      // reset after four matrix elements
      for (int i = 0; i < 4; i++) a_send(ops2[i], 1'b0);
      check("part_busy", a_busy, 1'b1);
      check("part_matrix", a_mvm_matrix, 72'h131415160506070809);
      a_rst_n = 1'b0;
      @(negedge clk);
      check("abort_matrix", a_mvm_matrix, 72'h0);
      check("abort_vector", a_mvm_vector, 24'h0);
      check("abort_in_ready", a_in_ready, 1'b0);
      check("abort_mvm_reset", a_mvm_reset, 1'b1);
      check("abort_busy", a_busy, 1'b0);
      check("abort_out", {a_out_valid, a_out_data}, 9'h0);
      a_rst_n = 1'b1;
      @(negedge clk);
      a_op(ops1, 8'h0E, 8'h20, 8'h32, 1'b0, 1'b0, 72'h010203040506070809, 24'h010203);

      // 2x4 with a 5-cycle backpressure stall mid-drain
      begin
         int n = 0;
         b_exp.push_back(8'h1E);
         b_exp.push_back(8'h46);
         b_out_ready = 1'b0;
         for (int i = 0; i < 12; i++) b_send(ops3[i]);
         while (!b_out_valid && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) fail_now("b_out_valid_wait");
         check("b_matrix", b_mvm_matrix, 64'h0102030405060708);
         check("b_vector", b_mvm_vector, 32'h01020304);
         b_out_ready = 1'b1;
         @(negedge clk);
         b_out_ready = 1'b0;
         repeat (5) @(negedge clk);
         check("b_stall_valid", b_out_valid, 1'b1);
         check("b_stall_data", b_out_data, 8'h46);
         b_out_ready = 1'b1;
         n = 0;
         while (b_busy && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) fail_now("b_idle_wait");
         check("b_drained", b_exp.size(), 0);
         check("b_err", b_err_timeout, 1'b0);
      end

`ifdef MVM_FEEDER_TIMEOUT_EN
      // mvm never answers: watchdog fires on the 16th WAIT cycle
      a_done_en = 1'b0;
      for (int i = 0; i < 12; i++) a_send(ops1[i], 1'b0);
      repeat (17) @(negedge clk);
      check("tmo_err_before", a_err_timeout, 1'b0);
      check("tmo_busy_before", a_busy, 1'b1);
      @(negedge clk);
      check("tmo_err", a_err_timeout, 1'b1);
      check("tmo_busy", a_busy, 1'b0);
      check("tmo_in_ready", a_in_ready, 1'b1);
      check("tmo_out_valid", a_out_valid, 1'b0);
      repeat (5) @(negedge clk);
      check("tmo_err_sticky", a_err_timeout, 1'b1);
      check("tmo_out_valid_late", a_out_valid, 1'b0);
`else
      check("a_err_never", a_err_timeout, 1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not reach its end, required completion");
      $fatal(1);
   end

endmodule
